k68_sasc_arb: RTL

Two-port arbiter and access sequencer for the k68 SASC UART register port. It shares the UART's single cs/we/add/dat interface between two requesters (m0, m1) using round-robin arbitration. Accesses to the DATA register are flow-controlled in hardware: before a DATA write the block polls STATUS until the TX FIFO is not full, and before a DATA read it polls until the RX FIFO is not empty. This removes software polling from both masters. The block sits between the requesters and the UART register port.

---
 rtl/k68_sasc_arb.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/k68_sasc_arb.sv
// Round-robin two-port arbiter in front of the SASC UART register port.
// It also polls STATUS in hardware before accessing the DATA register.
// Latency: unguarded write acks in cycle 2 and unguarded read in cycle 3. Each STATUS poll adds 2 cycles.
// Backpressure: a requester holds req until its ack. A port that loses arbitration waits with no side effects.

`ifndef k68_UART_ADR_DATA
`define k68_UART_ADR_DATA 16'h0000
`endif
`ifndef k68_UART_ADR_STATUS
`define k68_UART_ADR_STATUS 16'h0001
`endif

module k68_sasc_arb #(
    parameter logic [15:0] ADR_DATA   = `k68_UART_ADR_DATA,
    parameter logic [15:0] ADR_STATUS = `k68_UART_ADR_STATUS,
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic        clk_i,
    input  logic        nrst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [15:0] m0_add_i,
    input  logic [7:0]  m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [7:0]  m0_dat_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [15:0] m1_add_i,
    input  logic [7:0]  m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [7:0]  m1_dat_o,
    output logic        u_cs_o,
    output logic        u_we_o,
    output logic [15:0] u_add_o,
    output logic [7:0]  u_dat_o,
    input  logic [7:0]  u_dat_i,
    output logic [1:0]  grant_o
);

    localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_CHECK, S_ACCESS, S_RDATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        own_q, own_d;       // 0 = m0, 1 = m1
    logic [1:0]  grant_q, grant_d;
    logic        we_q, we_d;
    logic [15:0] add_q, add_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        last_q, last_d;     // last-served port
    logic [7:0]  rd0_q, rd0_d;
    logic [7:0]  rd1_q, rd1_d;

    // Arbitration winner: with both requesting, the port not served last wins.
    logic        sel;
    logic [15:0] sel_add;
    logic        fifo_ok;

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            own_q   <= 1'b0;
            grant_q <= 2'b00;
            we_q    <= 1'b0;
            add_q   <= 16'h0000;
            wdat_q  <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            rd0_q   <= 8'h00;
            rd1_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            add_q   <= add_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            last_q  <= last_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    // Next-state and datapath updates for the access sequencer.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        grant_d = grant_q;
        we_d    = we_q;
        add_d   = add_q;
        wdat_d  = wdat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        last_d  = last_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;

        sel     = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
        sel_add = sel ? m1_add_i : m0_add_i;
        // A write needs a TX FIFO that is not full (bit1). A read needs an RX FIFO that is not empty (bit0).
        fifo_ok = we_q ? ~u_dat_i[1] : ~u_dat_i[0];

        case (state_q)
            S_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    own_d   = sel;
                    grant_d = sel ? 2'b10 : 2'b01;
                    we_d    = sel ? m1_we_i : m0_we_i;
                    add_d   = sel_add;
                    wdat_d  = sel ? m1_dat_i : m0_dat_i;
                    err_d   = 1'b0;
                    if (sel_add == ADR_DATA) begin
                        cnt_d   = 8'h00;
                        state_d = S_POLL;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_POLL: begin
                cnt_d   = cnt_q + 8'h01;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (fifo_ok) begin
                    state_d = S_ACCESS;
                end else if (cnt_q == LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (own_q) rd1_d = 8'h00;
                        else       rd0_d = 8'h00;
                    end
                end else begin
                    state_d = S_POLL;
                end
            end
            S_ACCESS: begin
                state_d = we_q ? S_DONE : S_RDATA;
            end
            S_RDATA: begin
                if (own_q) rd1_d = u_dat_i;
                else       rd0_d = u_dat_i;
                state_d = S_DONE;
            end
            S_DONE: begin
                last_d  = own_q;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // UART strobes are decoded from state, so an async reset drops cs at once.
    assign u_cs_o   = (state_q == S_POLL) || (state_q == S_ACCESS);
    assign u_we_o   = (state_q == S_ACCESS) && we_q;
    assign u_add_o  = (state_q == S_POLL)   ? ADR_STATUS :
                      (state_q == S_ACCESS) ? add_q : 16'h0000;
    assign u_dat_o  = ((state_q == S_ACCESS) && we_q) ? wdat_q : 8'h00;

    assign m0_ack_o = (state_q == S_DONE) && !own_q;
    assign m1_ack_o = (state_q == S_DONE) &&  own_q;
    assign m0_err_o = m0_ack_o && err_q;
    assign m1_err_o = m1_ack_o && err_q;
    assign m0_dat_o = rd0_q;
    assign m1_dat_o = rd1_q;
    assign grant_o  = grant_q;

endmodule
